// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header extractor.
// Optional feature macro used by the top: AXIS_EXTRACT_LEN_EN (payload byte counter).
package axis_hdr_pkg;

  localparam int DEF_DATA_WD      = 32;
  localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
  localparam int MAX_LANES        = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BODY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Low n bits set; callers size-cast the result to their lane count.
  function automatic logic [MAX_LANES-1:0] cnt_to_keep(input int unsigned n);
    logic [MAX_LANES-1:0] keep;
    keep = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      keep[i] = (i < n);
    end
    return keep;
  endfunction

  function automatic int unsigned keep_to_cnt(input logic [MAX_LANES-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational byte shifter: merges the held residual with the top H bytes of the
// incoming beat and derives header/residual data and keep for a given H.
module axis_byte_realign
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [BYTE_CNT_WD:0]    hdr_bytes_i,
  input  logic [DATA_WD-1:0]      res_data_i,
  input  logic [DATA_BYTE_WD-1:0] res_keep_i,
  input  logic [DATA_WD-1:0]      data_i,
  input  logic [DATA_BYTE_WD-1:0] keep_i,
  output logic [DATA_WD-1:0]      merged_data_o,
  output logic [DATA_BYTE_WD-1:0] merged_keep_o,
  output logic [DATA_WD-1:0]      hdr_data_o,
  output logic [DATA_BYTE_WD-1:0] hdr_keep_o,
  output logic [DATA_WD-1:0]      next_res_data_o,
  output logic [DATA_BYTE_WD-1:0] next_res_keep_o
);

  logic [31:0]        h_lanes;
  logic [31:0]        tail_lanes;
  logic [DATA_WD-1:0] top_bytes;

  assign h_lanes    = 32'(hdr_bytes_i);
  assign tail_lanes = 32'(DATA_BYTE_WD) - h_lanes;

  // The first H bytes of the beat moved down into the low lanes.
  assign top_bytes = data_i >> (tail_lanes << 3);

  assign merged_data_o   = res_data_i | top_bytes;
  assign merged_keep_o   = res_keep_i | (keep_i >> tail_lanes);
  assign hdr_data_o      = top_bytes;
  assign hdr_keep_o      = DATA_BYTE_WD'(cnt_to_keep(h_lanes));
  assign next_res_data_o = data_i << (h_lanes << 3);
  assign next_res_keep_o = keep_i << h_lanes;

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..B byte header from the first beat of each packet and realigns the payload.
// Define AXIS_EXTRACT_LEN_EN to add a saturating payload byte count output.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic                    valid_header,
  input  logic                    ready_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header
`ifdef AXIS_EXTRACT_LEN_EN
  ,
  output logic [15:0]             payload_len
`endif
);

  state_e                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d, cnt_sel;
  logic [BYTE_CNT_WD:0]    hdr_bytes;
  logic [DATA_WD-1:0]      res_data_q, res_data_d;
  logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;
  logic                    out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [DATA_WD-1:0]      out_data_q, out_data_d;
  logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
  logic                    hdr_vld_q, hdr_vld_d;
  logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;
  logic                    out_free, hdr_free, out_load;

  logic [DATA_WD-1:0]      merged_data, hdr_data, nxt_res_data;
  logic [DATA_BYTE_WD-1:0] merged_keep, hdr_keep, nxt_res_keep;

  // H is taken live from the input on the first beat and from the latched copy afterwards.
  assign cnt_sel   = (state_q == ST_IDLE) ? byte_extract_cnt : cnt_q;
  assign hdr_bytes = {1'b0, cnt_sel} + {{BYTE_CNT_WD{1'b0}}, 1'b1};
  assign out_free  = ~out_vld_q | ready_out;
  assign hdr_free  = ~hdr_vld_q | ready_header;

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_realign (
    .hdr_bytes_i     (hdr_bytes),
    .res_data_i      (res_data_q),
    .res_keep_i      (res_keep_q),
    .data_i          (data_in),
    .keep_i          (keep_in),
    .merged_data_o   (merged_data),
    .merged_keep_o   (merged_keep),
    .hdr_data_o      (hdr_data),
    .hdr_keep_o      (hdr_keep),
    .next_res_data_o (nxt_res_data),
    .next_res_keep_o (nxt_res_keep)
  );

  // NOTE: every value written here is defaulted first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_keep_d = res_keep_q;
    out_vld_d  = out_vld_q & ~ready_out;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    hdr_vld_d  = hdr_vld_q & ~ready_header;
    hdr_data_d = hdr_data_q;
    hdr_keep_d = hdr_keep_q;
    out_load   = 1'b0;
    ready_in   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_in = rst_n & hdr_free & out_free;
        if (valid_in && ready_in) begin
          hdr_vld_d  = 1'b1;
          hdr_data_d = hdr_data;
          hdr_keep_d = hdr_keep;
          cnt_d      = byte_extract_cnt;
          res_data_d = nxt_res_data;
          res_keep_d = nxt_res_keep;
          if (!last_in)                           state_d = ST_BODY;
          else if (nxt_res_keep[DATA_BYTE_WD-1])  state_d = ST_FLUSH;
        end
      end
      ST_BODY: begin
        ready_in = rst_n & out_free;
        if (valid_in && ready_in) begin
          out_load   = 1'b1;
          out_data_d = merged_data;
          res_data_d = nxt_res_data;
          res_keep_d = nxt_res_keep;
          if (!last_in) begin
            out_keep_d = '1;
            out_last_d = 1'b0;
          end else if (nxt_res_keep[DATA_BYTE_WD-1]) begin
            // More bytes remain than fit after the residual: one extra beat follows.
            out_keep_d = '1;
            out_last_d = 1'b0;
            state_d    = ST_FLUSH;
          end else begin
            out_keep_d = merged_keep;
            out_last_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          out_load   = 1'b1;
          out_data_d = res_data_q;
          out_keep_d = res_keep_q;
          out_last_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_load) out_vld_d = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      // NOTE: datapath registers are cleared too, so every output reads zero in reset.
      res_data_q <= '0;
      res_keep_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      hdr_vld_q  <= 1'b0;
      hdr_data_q <= '0;
      hdr_keep_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_keep_q <= res_keep_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      hdr_vld_q  <= hdr_vld_d;
      hdr_data_q <= hdr_data_d;
      hdr_keep_q <= hdr_keep_d;
    end
  end

  assign valid_out    = out_vld_q;
  assign data_out     = out_data_q;
  assign keep_out     = out_keep_q;
  assign last_out     = out_last_q;
  assign valid_header = hdr_vld_q;
  assign data_header  = hdr_data_q;
  assign keep_header  = hdr_keep_q;

`ifdef AXIS_EXTRACT_LEN_EN
  logic [15:0] len_acc_q, len_acc_d, len_q, len_d;
  logic [16:0] len_sum;

  // Running byte total over emitted beats; the value presented with last_out is the packet total.
  always_comb begin
    len_acc_d = len_acc_q;
    len_d     = len_q;
    len_sum   = {1'b0, len_acc_q} + 17'(keep_to_cnt(MAX_LANES'(out_keep_d)));
    if (out_load) begin
      len_d     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
      len_acc_d = out_last_d ? 16'h0000 : len_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_acc_q <= '0;
      len_q     <= '0;
    end else begin
      len_acc_q <= len_acc_d;
      len_q     <= len_d;
    end
  end

  assign payload_len = len_q;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Randomized bench for axi_stream_extract_header: a byte-list packet model predicts
// header and realigned payload beats; a monitor scores everything that leaves the DUT.
module tb_axi_stream_extract_header;
  import axis_hdr_pkg::*;

  localparam int DW = DEF_DATA_WD;
  localparam int B  = DEF_DATA_BYTE_WD;
  localparam int CW = $clog2(B);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, ready_in, last_in;
  logic [DW-1:0] data_in;
  logic [B-1:0]  keep_in;
  logic [CW-1:0] byte_extract_cnt;
  logic          valid_out, last_out;
  logic          ready_out = 1'b1;
  logic [DW-1:0] data_out;
  logic [B-1:0]  keep_out;
  logic          valid_header;
  logic          ready_header = 1'b1;
  logic [DW-1:0] data_header;
  logic [B-1:0]  keep_header;
`ifdef AXIS_EXTRACT_LEN_EN
  logic [15:0]   payload_len;
`endif

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .ready_in         (ready_in),
    .data_in          (data_in),
    .keep_in          (keep_in),
    .last_in          (last_in),
    .byte_extract_cnt (byte_extract_cnt),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .data_out         (data_out),
    .keep_out         (keep_out),
    .last_out         (last_out),
    .valid_header     (valid_header),
    .ready_header     (ready_header),
    .data_header      (data_header),
    .keep_header      (keep_header)
`ifdef AXIS_EXTRACT_LEN_EN
    ,
    .payload_len      (payload_len)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [DW-1:0] d, input logic [B-1:0] k,
                                        input logic l);
    logic [127:0] v;
    v = '0;
    v[DW-1:0]     = d;
    v[DW]         = l;
    v[DW+B:DW+1]  = k;
    return v;
  endfunction

  logic [127:0] exp_pay[$], exp_hdr[$], rx_pay[$], rx_hdr[$];
  byte unsigned pkt_bytes[$];
  logic mon_en   = 1'b0;
  logic rand_rdy = 1'b0;
  logic rand_gap = 1'b0;

  // Ready generators: change only on the falling edge.
  always begin
    @(negedge clk);
    if (rand_rdy) begin
      ready_out    = ($urandom_range(0, 3) != 0);
      ready_header = ($urandom_range(0, 2) != 0);
    end else begin
      ready_out    = 1'b1;
      ready_header = 1'b1;
    end
  end

  // Monitor: values seen here are the ones the next rising edge acts on.
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  always begin
    logic [127:0] v;
    @(negedge clk);
    #2;
    if (mon_en && rst_n) begin
      if (hold_pend) check("hdr_hold", {95'd0, valid_header, data_header}, {95'd0, 1'b1, hold_data});
      hold_pend = valid_header && !ready_header;
      hold_data = data_header;
      if (valid_header && ready_header) begin
        v = pack(data_header, keep_header, 1'b0);
        rx_hdr.push_back(v);
        check("hdr_expected", 128'(exp_hdr.size() != 0), 128'(1));
        if (exp_hdr.size() != 0) check("hdr_beat", v, exp_hdr.pop_front());
      end
      if (valid_out && ready_out) begin
        v = pack(data_out, keep_out, last_out);
        rx_pay.push_back(v);
        check("pay_expected", 128'(exp_pay.size() != 0), 128'(1));
        if (exp_pay.size() != 0) check("pay_beat", v, exp_pay.pop_front());
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_beat(input logic [DW-1:0] d, input logic [B-1:0] k, input logic l);
    logic acc;
    if (rand_gap) begin
      while ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        @(negedge clk);
      end
    end
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    acc      = 1'b0;
    for (int c = 0; c < 300 && !acc; c++) begin
      #1;
      acc = ready_in;
      @(negedge clk);
    end
    valid_in = 1'b0;
    check("in_accept", 128'(acc), 128'(1));
  endtask

  // Model: header = first H bytes right-aligned; payload = remaining bytes packed MSB-first.
  task automatic send_packet(input int h);
    int           len, nb, p, chunk;
    logic [DW-1:0] dv;
    logic [B-1:0]  kv;
    len = pkt_bytes.size();
    nb  = (len + B - 1) / B;
    dv  = '0;
    for (int k = 0; k < h; k++) dv[8*(h-1-k) +: 8] = pkt_bytes[k];
    kv  = B'((1 << h) - 1);
    exp_hdr.push_back(pack(dv, kv, 1'b0));
    p = len - h;
    for (int s = 0; s < p; s += B) begin
      chunk = (p - s < B) ? p - s : B;
      dv = '0;
      kv = '0;
      for (int j = 0; j < chunk; j++) begin
        dv[8*(B-1-j) +: 8] = pkt_bytes[h+s+j];
        kv[B-1-j]          = 1'b1;
      end
      exp_pay.push_back(pack(dv, kv, (s + B >= p)));
    end
    byte_extract_cnt = CW'(h - 1);
    for (int i = 0; i < nb; i++) begin
      dv = '0;
      kv = '0;
      for (int j = 0; j < B; j++) begin
        if (i*B + j < len) begin
          dv[8*(B-1-j) +: 8] = pkt_bytes[i*B+j];
          kv[B-1-j]          = 1'b1;
        end
      end
      send_beat(dv, kv, (i == nb - 1));
      if (i == 0) byte_extract_cnt = CW'($urandom);
    end
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_pay_left"}, 128'(exp_pay.size()), 128'(0));
    check({tag, "_hdr_left"}, 128'(exp_hdr.size()), 128'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    keep_in = '0;
    last_in = 1'b0;
    byte_extract_cnt = '0;
    #3;
    check("rst_ready_in", 128'(ready_in), 128'(0));
    check("rst_valid_out", 128'(valid_out), 128'(0));
    check("rst_valid_header", 128'(valid_header), 128'(0));
    check("rst_out_beat", pack(data_out, keep_out, last_out), 128'(0));
    check("rst_hdr_beat", pack(data_header, keep_header, 1'b0), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Two-byte header, trailing residual flush.
    rx_pay.delete(); rx_hdr.delete();
    pkt_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h8F};
    send_packet(2);
    drain("h2");
    check("h2_pay_cnt", 128'(rx_pay.size()), 128'(3));
    if (rx_hdr.size() >= 1) check("h2_hdr", rx_hdr[0], pack(32'h0000AABB, 4'b0011, 1'b0));
    if (rx_pay.size() >= 3) begin
      check("h2_pay0", rx_pay[0], pack(32'hCCDD1122, 4'b1111, 1'b0));
      check("h2_pay1", rx_pay[1], pack(32'h33445566, 4'b1111, 1'b0));
      check("h2_pay2", rx_pay[2], pack(32'h778F0000, 4'b1100, 1'b1));
    end

    // Full-width header: payload passes through unshifted.
    rx_pay.delete(); rx_hdr.delete();
    pkt_bytes.delete();
    for (int i = 0; i < 12; i++) pkt_bytes.push_back(8'(8'h10 + i));
    send_packet(4);
    drain("h4");
    if (rx_hdr.size() >= 1) check("h4_hdr", rx_hdr[0], pack(32'h10111213, 4'b1111, 1'b0));
    if (rx_pay.size() >= 2) check("h4_pay1", rx_pay[1], pack(32'h18191A1B, 4'b1111, 1'b1));

    // Single short beat with payload left over.
    rx_pay.delete(); rx_hdr.delete();
    pkt_bytes = '{8'h01, 8'h02, 8'h03};
    send_packet(1);
    drain("h1");
    if (rx_hdr.size() >= 1) check("h1_hdr", rx_hdr[0], pack(32'h00000001, 4'b0001, 1'b0));
    check("h1_pay_cnt", 128'(rx_pay.size()), 128'(1));
    if (rx_pay.size() >= 1) check("h1_pay", rx_pay[0], pack(32'h02030000, 4'b1100, 1'b1));

    // Three-byte header with a full last beat: the flush cycle blocks the input.
    rx_pay.delete(); rx_hdr.delete();
    pkt_bytes = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};
    send_packet(3);
    #1;
    check("flush_ready_in", 128'(ready_in), 128'(0));
    drain("h3");
    if (rx_pay.size() >= 2) check("h3_flush", rx_pay[1], pack(32'hF7000000, 4'b1000, 1'b1));

    // Random packets under random back-pressure and input gaps.
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      int h, len;
      h   = $urandom_range(1, B);
      len = $urandom_range(h, 4*B + 3);
      pkt_bytes.delete();
      for (int i = 0; i < len; i++) pkt_bytes.push_back(8'($urandom));
      send_packet(h);
    end
    drain("rand");

    // Reset in the middle of a packet body.
    rand_rdy = 1'b0;
    rand_gap = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    byte_extract_cnt = CW'(1);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_out", 128'(valid_out), 128'(0));
    check("mid_rst_valid_header", 128'(valid_header), 128'(0));
    check("mid_rst_ready_in", 128'(ready_in), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_pay.delete(); exp_hdr.delete(); rx_pay.delete(); rx_hdr.delete();
    @(negedge clk);
    mon_en = 1'b1;
    pkt_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_packet(2);
    drain("post_rst");
    if (rx_hdr.size() >= 1) check("post_rst_hdr", rx_hdr[0], pack(32'h0000A1A2, 4'b0011, 1'b0));
    check("post_rst_pay_cnt", 128'(rx_pay.size()), 128'(1));
    if (rx_pay.size() >= 1) check("post_rst_pay", rx_pay[0], pack(32'hA3A4A5A6, 4'b1111, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
